// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch and
// data load/store requesters. Data wins by default; a starvation counter forces
// a fetch grant after STARVE_LIMIT data grants taken while a fetch was waiting.
// Each transaction is captured at grant and held until mem_ready or timeout.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,   // 1..15
    parameter int TIMEOUT_CYCLES = 64   // 0 disables the timeout
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_ren,
    input  logic [31:0] imem_addr,
    output logic        ihit,
    output logic [31:0] imem_load,

    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_store,
    input  logic [2:0]  dmem_width,
    output logic        dhit,
    output logic [31:0] dmem_load,

    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    output logic [2:0]  mem_width,
    input  logic        mem_ready,
    input  logic [31:0] mem_load,

    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    // The counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int              TMO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic             TMO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0]       FETCH_WIDTH = 3'b010;

    state_t           state;
    state_t           next_state;
    logic [3:0]       starve_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    // Transaction captured at grant; the memory port is driven only from these.
    logic [31:0]      i_addr_q;
    logic [31:0]      d_addr_q;
    logic [31:0]      d_store_q;
    logic [2:0]       d_width_q;
    logic             d_ren_q;
    logic             d_wen_q;

    logic             data_req;
    logic             grant_data;
    logic             grant_fetch;
    logic             timed_out;

    assign data_req    = dmem_ren | dmem_wen;
    assign grant_data  = data_req && (!imem_ren || (starve_cnt < STARVE_MAX));
    assign grant_fetch = !grant_data && imem_ren;
    assign timed_out   = TMO_EN && (state != IDLE) && !mem_ready && (tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: arbitrate in IDLE, return to IDLE on completion or timeout.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (grant_data) begin
                    next_state = DBUSY;
                end else if (grant_fetch) begin
                    next_state = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready || timed_out) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the granted request, track starvation and the busy-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            i_addr_q   <= '0;
            d_addr_q   <= '0;
            d_store_q  <= '0;
            d_width_q  <= '0;
            d_ren_q    <= 1'b0;
            d_wen_q    <= 1'b0;
        end else if (state == IDLE) begin
            // Clearing while idle means every transaction starts counting from zero.
            tmo_cnt <= '0;
            if (grant_data) begin
                d_addr_q  <= dmem_addr;
                d_store_q <= dmem_store;
                d_width_q <= dmem_width;
                // A simultaneous read and write request is treated as a store.
                d_ren_q   <= dmem_ren & ~dmem_wen;
                d_wen_q   <= dmem_wen;
                // A data grant over a waiting fetch implies starve_cnt < STARVE_MAX,
                // so the increment saturates at the limit by construction.
                if (imem_ren) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (grant_fetch) begin
                i_addr_q   <= imem_addr;
                starve_cnt <= '0;
            end
        end else if (TMO_EN && !mem_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Output decode: memory strobes from latched state, hits from mem_ready.
    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_store = '0;
        mem_width = '0;
        ihit      = 1'b0;
        imem_load = '0;
        dhit      = 1'b0;
        dmem_load = '0;
        bus_err   = 1'b0;
        unique case (state)
            IBUSY: begin
                mem_ren   = 1'b1;
                mem_addr  = i_addr_q;
                mem_width = FETCH_WIDTH;
                ihit      = mem_ready;
                imem_load = mem_ready ? mem_load : '0;
                bus_err   = timed_out;
            end
            DBUSY: begin
                mem_ren   = d_ren_q;
                mem_wen   = d_wen_q;
                mem_addr  = d_addr_q;
                mem_store = d_store_q;
                mem_width = d_width_q;
                dhit      = mem_ready;
                dmem_load = mem_ready ? mem_load : '0;
                bus_err   = timed_out;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT   = 2;
    localparam int TIMEOUT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imem_load;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [2:0]  dmem_width;
    logic        dhit;
    logic [31:0] dmem_load;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_store;
    logic [2:0]  mem_width;
    logic        mem_ready;
    logic [31:0] mem_load;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT   (STARVE_LIMIT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .ihit       (ihit),
        .imem_load  (imem_load),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .dmem_store (dmem_store),
        .dmem_width (dmem_width),
        .dhit       (dhit),
        .dmem_load  (dmem_load),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_store  (mem_store),
        .mem_width  (mem_width),
        .mem_ready  (mem_ready),
        .mem_load   (mem_load),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        imem_ren   = 1'b0;
        imem_addr  = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_store = '0;
        dmem_width = '0;
        mem_ready  = 1'b0;
        mem_load   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_load  = 32'hFFFF_FFFF;
        tick();
        tick();
        settle();
        tests++;
        if ({mem_ren, mem_wen, ihit, dhit, bus_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b expected %b", {mem_ren, mem_wen, ihit, dhit, bus_err}, 5'b0);
        end
        tests++;
        if ({mem_addr, mem_store, mem_width, imem_load, dmem_load} !== '0) begin
            fails++;
            $display("FAIL reset_buses: got %h expected 0", {mem_addr, mem_store, mem_width, imem_load, dmem_load});
        end
        rst = 1'b0;
        tick();
        settle();
        tests++;
        if ({ihit, dhit, mem_ren, bus_err} !== 4'b0) begin
            fails++;
            $display("FAIL idle_ready_ignored: got %b expected %b", {ihit, dhit, mem_ren, bus_err}, 4'b0);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_fetch_only();
        idle_inputs();
        imem_ren  = 1'b1;
        imem_addr = 32'h0000_0100;
        settle();
        tests++;
        if (mem_ren !== 1'b0) begin
            fails++;
            $display("FAIL fetch_no_comb_path: got mem_ren=%b expected 0", mem_ren);
        end
        tick();
        settle();
        tests++;
        if ({mem_ren, mem_wen, mem_addr, mem_width, ihit} !== {1'b1, 1'b0, 32'h100, 3'b010, 1'b0}) begin
            fails++;
            $display("FAIL fetch_strobe: got ren=%b wen=%b addr=%h width=%b ihit=%b expected 1 0 00000100 010 0",
                     mem_ren, mem_wen, mem_addr, mem_width, ihit);
        end
        tick();
        settle();
        tests++;
        if ({mem_ren, ihit, bus_err} !== 3'b100) begin
            fails++;
            $display("FAIL fetch_wait: got ren/ihit/berr=%b expected 100", {mem_ren, ihit, bus_err});
        end
        tick();
        mem_ready = 1'b1;
        mem_load  = 32'h0000_0013;
        settle();
        tests++;
        if ({ihit, imem_load, dhit, bus_err} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL fetch_hit: got ihit=%b load=%h dhit=%b berr=%b expected 1 00000013 0 0",
                     ihit, imem_load, dhit, bus_err);
        end
        tick();
        idle_inputs();
        settle();
        tests++;
        if ({mem_ren, ihit, imem_load} !== '0) begin
            fails++;
            $display("FAIL fetch_back_idle: got ren=%b ihit=%b load=%h expected 0 0 0", mem_ren, ihit, imem_load);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        imem_ren   = 1'b1;
        imem_addr  = 32'h0000_0400;
        dmem_ren   = 1'b1;
        dmem_addr  = 32'h0000_2000;
        dmem_width = 3'b010;
        mem_ready  = 1'b1;
        mem_load   = 32'hA5A5_0001;
        settle();
        tests++;
        if ({ihit, dhit, mem_ren} !== 3'b0) begin
            fails++;
            $display("FAIL simul_idle: got ihit/dhit/ren=%b expected 000", {ihit, dhit, mem_ren});
        end
        tick();
        settle();
        tests++;
        if ({mem_ren, mem_wen, mem_addr, mem_width, dhit, dmem_load, ihit}
            !== {1'b1, 1'b0, 32'h2000, 3'b010, 1'b1, 32'hA5A5_0001, 1'b0}) begin
            fails++;
            $display("FAIL simul_data_first: got ren=%b wen=%b addr=%h w=%b dhit=%b load=%h ihit=%b expected 1 0 00002000 010 1 a5a50001 0",
                     mem_ren, mem_wen, mem_addr, mem_width, dhit, dmem_load, ihit);
        end
        tick();
        dmem_ren = 1'b0;
        settle();
        tests++;
        if ({mem_ren, ihit, dhit} !== 3'b0) begin
            fails++;
            $display("FAIL simul_gap: got ren/ihit/dhit=%b expected 000", {mem_ren, ihit, dhit});
        end
        tick();
        mem_load = 32'h0000_0013;
        settle();
        tests++;
        if ({mem_ren, mem_addr, mem_width, ihit, imem_load, dhit}
            !== {1'b1, 32'h400, 3'b010, 1'b1, 32'h13, 1'b0}) begin
            fails++;
            $display("FAIL simul_fetch_second: got ren=%b addr=%h w=%b ihit=%b load=%h dhit=%b expected 1 00000400 010 1 00000013 0",
                     mem_ren, mem_addr, mem_width, ihit, imem_load, dhit);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_store();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            dmem_wen   = 1'b1;
            dmem_ren   = (k == 1);
            dmem_addr  = 32'h0000_3004;
            dmem_store = 32'hDEAD_BEEF;
            dmem_width = 3'b001;
            tick();
            // Requester lines change mid-transaction; the port must not follow.
            dmem_addr  = 32'hFFFF_0000;
            dmem_store = 32'h0;
            dmem_width = 3'b111;
            dmem_wen   = 1'b0;
            dmem_ren   = 1'b1;
            settle();
            tests++;
            if ({mem_ren, mem_wen, mem_addr, mem_store, mem_width, dhit}
                !== {1'b0, 1'b1, 32'h3004, 32'hDEAD_BEEF, 3'b001, 1'b0}) begin
                fails++;
                $display("FAIL store_strobe_%0d: got ren=%b wen=%b addr=%h data=%h w=%b dhit=%b expected 0 1 00003004 deadbeef 001 0",
                         k, mem_ren, mem_wen, mem_addr, mem_store, mem_width, dhit);
            end
            tick();
            mem_ready = 1'b1;
            settle();
            tests++;
            if ({dhit, mem_wen, mem_addr, ihit} !== {1'b1, 1'b1, 32'h3004, 1'b0}) begin
                fails++;
                $display("FAIL store_hit_%0d: got dhit=%b wen=%b addr=%h ihit=%b expected 1 1 00003004 0",
                         k, dhit, mem_wen, mem_addr, ihit);
            end
            tick();
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        imem_ren  = 1'b1;
        imem_addr = 32'h0000_0500;
        tick();
        for (int c = 1; c <= 3; c++) begin
            settle();
            tests++;
            if ({mem_ren, bus_err, ihit} !== 3'b100) begin
                fails++;
                $display("FAIL timeout_wait_%0d: got ren/berr/ihit=%b expected 100", c, {mem_ren, bus_err, ihit});
            end
            tick();
        end
        settle();
        tests++;
        if ({bus_err, ihit, dhit, mem_ren} !== 4'b1001) begin
            fails++;
            $display("FAIL timeout_err: got berr/ihit/dhit/ren=%b expected 1001", {bus_err, ihit, dhit, mem_ren});
        end
        tick();
        imem_ren = 1'b0;
        settle();
        tests++;
        if ({bus_err, mem_ren, ihit} !== 3'b0) begin
            fails++;
            $display("FAIL timeout_idle: got berr/ren/ihit=%b expected 000", {bus_err, mem_ren, ihit});
        end
        imem_ren  = 1'b1;
        imem_addr = 32'h0000_0600;
        tick();
        tick();
        tick();
        tick();
        mem_ready = 1'b1;
        mem_load  = 32'h0000_0077;
        settle();
        tests++;
        if ({ihit, imem_load, bus_err} !== {1'b1, 32'h77, 1'b0}) begin
            fails++;
            $display("FAIL timeout_ready_wins: got ihit=%b load=%h berr=%b expected 1 00000077 0",
                     ihit, imem_load, bus_err);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        dmem_ren  = 1'b1;
        dmem_addr = 32'h0000_2400;
        imem_ren  = 1'b1;
        imem_addr = 32'h0000_0700;
        tick();
        settle();
        tests++;
        if ({mem_ren, dhit} !== 2'b10) begin
            fails++;
            $display("FAIL rstmid_busy: got ren/dhit=%b expected 10", {mem_ren, dhit});
        end
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        dmem_ren  = 1'b0;
        imem_ren  = 1'b0;
        mem_ready = 1'b1;
        mem_load  = 32'h1234_5678;
        settle();
        tests++;
        if ({dhit, ihit, mem_ren, mem_wen, bus_err} !== 5'b0) begin
            fails++;
            $display("FAIL rstmid_idle: got dhit/ihit/ren/wen/berr=%b expected 00000", {dhit, ihit, mem_ren, mem_wen, bus_err});
        end
        tick();
        idle_inputs();
        tick();
    endtask

    // Follows test_reset_mid, so the grant order also shows the starvation count was cleared.
    task automatic test_starvation();
        string got;
        int    cycles;
        got    = "";
        cycles = 0;
        idle_inputs();
        dmem_wen  = 1'b1;
        dmem_addr = 32'h0000_0800;
        imem_ren  = 1'b1;
        imem_addr = 32'h0000_0900;
        mem_ready = 1'b1;
        for (int c = 0; c < 40 && got.len() < 6; c++) begin
            settle();
            if (dhit) got = {got, "D"};
            else if (ihit) got = {got, "I"};
            tick();
            cycles = c + 1;
        end
        tests++;
        if (got != "DDIDDI") begin
            fails++;
            $display("FAIL starve_order: got %s expected DDIDDI", got);
        end
        tests++;
        if (cycles != 12) begin
            fails++;
            $display("FAIL starve_cycles: got %0d expected 12", cycles);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    typedef enum {M_NONE, M_FETCH, M_DATA} mkind_t;

    task automatic test_random();
        mkind_t       kind;
        logic [31:0]  t_addr;
        logic [31:0]  t_store;
        logic [2:0]   t_width;
        logic         t_wr;
        int           waited;
        int           starve;
        logic         e_ren, e_wen, e_ihit, e_dhit, e_berr;
        logic [31:0]  e_addr, e_store, e_iload, e_dload, g_store;
        logic [2:0]   e_width;
        logic [135:0] exp_v, got_v;
        kind    = M_NONE;
        t_addr  = '0;
        t_store = '0;
        t_width = '0;
        t_wr    = 1'b0;
        waited  = 0;
        starve  = 0;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            // Requester behaviour: raise, occasionally abandon, hold otherwise.
            if (!imem_ren && $urandom_range(0, 2) == 0) begin
                imem_ren  = 1'b1;
                imem_addr = $urandom;
            end else if (imem_ren && $urandom_range(0, 19) == 0) begin
                imem_ren = 1'b0;
            end
            if (!(dmem_ren || dmem_wen) && $urandom_range(0, 2) == 0) begin
                dmem_ren   = 1'($urandom_range(0, 1));
                dmem_wen   = !dmem_ren || ($urandom_range(0, 3) == 0);
                dmem_addr  = $urandom;
                dmem_width = 3'($urandom_range(0, 7));
            end else if ((dmem_ren || dmem_wen) && $urandom_range(0, 19) == 0) begin
                dmem_ren = 1'b0;
                dmem_wen = 1'b0;
            end
            dmem_store = $urandom;
            mem_ready  = ($urandom_range(0, 9) < 4);
            mem_load   = $urandom;
            settle();

            {e_ren, e_wen, e_ihit, e_dhit, e_berr} = '0;
            {e_addr, e_store, e_iload, e_dload}    = '0;
            e_width = '0;
            if (kind == M_FETCH) begin
                e_ren   = 1'b1;
                e_addr  = t_addr;
                e_width = 3'b010;
                if (mem_ready) begin
                    e_ihit  = 1'b1;
                    e_iload = mem_load;
                end else if (waited == TIMEOUT_CYCLES - 1) begin
                    e_berr = 1'b1;
                end
            end else if (kind == M_DATA) begin
                e_ren   = !t_wr;
                e_wen   = t_wr;
                e_addr  = t_addr;
                e_store = t_store;
                e_width = t_width;
                if (mem_ready) begin
                    e_dhit  = 1'b1;
                    e_dload = mem_load;
                end else if (waited == TIMEOUT_CYCLES - 1) begin
                    e_berr = 1'b1;
                end
            end
            // Store data is unspecified during a fetch, so it is masked there.
            g_store = (kind == M_FETCH) ? 32'h0 : mem_store;
            exp_v = {e_ren, e_wen, e_addr, e_store, e_width, e_ihit, e_dhit, e_iload, e_dload, e_berr};
            got_v = {mem_ren, mem_wen, mem_addr, g_store, mem_width, ihit, dhit, imem_load, dmem_load, bus_err};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL random_cycle_%0d: got %h expected %h", c, got_v, exp_v);
            end

            // Model update for the coming edge.
            if (kind != M_NONE) begin
                if (mem_ready || waited == TIMEOUT_CYCLES - 1) kind = M_NONE;
                else waited++;
            end else if ((dmem_ren || dmem_wen) && (!imem_ren || starve < STARVE_LIMIT)) begin
                kind    = M_DATA;
                t_addr  = dmem_addr;
                t_store = dmem_store;
                t_width = dmem_width;
                t_wr    = dmem_wen;
                waited  = 0;
                if (imem_ren && starve < STARVE_LIMIT) starve++;
            end else if (imem_ren) begin
                kind   = M_FETCH;
                t_addr = imem_addr;
                waited = 0;
                starve = 0;
            end
            tick();
            if (e_ihit) imem_ren = 1'b0;
            if (e_dhit) begin
                dmem_ren = 1'b0;
                dmem_wen = 1'b0;
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_timeout();
        test_reset_mid();
        test_starvation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester and data load/store requester.
- Sits between the datapath's imem/dmem signal groups and the memory/bus adapter.
- Data has priority by default, with a starvation limit that forces an instruction grant.
- Each transaction is latched at grant and held until memory handshake completion or timeout.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (1..15)
TIMEOUT_CYCLES, 64, cycles to wait for mem_ready before aborting; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
imem_ren  in  1  fetch request, held until ihit
imem_addr  in  32  fetch address
ihit  out  1  fetch complete, 1-cycle pulse
imem_load  out  32  fetch data, valid when ihit
dmem_ren  in  1  load request, held until dhit
dmem_wen  in  1  store request, held until dhit
dmem_addr  in  32  data address
dmem_store  in  32  store data
dmem_width  in  3  load/store width code, passed through unchanged
dhit  out  1  data complete, 1-cycle pulse
dmem_load  out  32  load data, valid when dhit
mem_ren  out  1  memory read strobe
mem_wen  out  1  memory write strobe
mem_addr  out  32  memory address
mem_store  out  32  memory write data
mem_width  out  3  memory access width (fetch always 3'b010)
mem_ready  in  1  memory completes current access this cycle
mem_load  in  32  memory read data, valid with mem_ready
bus_err  out  1  timeout pulse, 1 cycle

Behaviour:
- States: IDLE, IBUSY, DBUSY.
- Reset (sync, rst=1 at edge): state=IDLE; starve_cnt=0; timeout counter=0; latched request regs=0. All outputs 0 while in IDLE after reset.
- IDLE arbitration at each edge:
  - Data request pending = dmem_ren|dmem_wen.
  - If data pending and (no fetch, or starve_cnt < STARVE_LIMIT): latch addr/store/width/ren/wen; go to DBUSY. If fetch was also pending, starve_cnt++.
  - Else if fetch pending: latch imem_addr; go to IBUSY; starve_cnt=0.
  - Else stay IDLE.
- dmem_ren and dmem_wen both high: treat as a store (wen wins, ren dropped).
- Busy states: mem_* are driven only from latched registers; requester inputs are ignored mid-transaction.
  - IBUSY: mem_ren=1, mem_wen=0, mem_width=3'b010, mem_addr=latched fetch address.
  - DBUSY: mem_ren/mem_wen/mem_addr/mem_store/mem_width from latched data request.
- Completion: mem_ready=1 in a busy state gives a combinational ihit (IBUSY) or dhit (DBUSY) in the same cycle. imem_load/dmem_load = mem_load that cycle, else 0. Next state is IDLE.
- Minimum latency: request seen at edge N, mem strobe in cycle N+1, hit in the mem_ready cycle (≥ N+1), new arbitration at the following edge. There is one forced IDLE cycle between transactions.
- mem_ready in IDLE is ignored; no hit is generated.
- Requester dropping its request mid-transaction: the access still completes and the hit still pulses. Requesters discard it.
- Timeout (TIMEOUT_CYCLES>0): the counter clears on entering a busy state and increments each busy cycle without mem_ready. When it reaches TIMEOUT_CYCLES-1 with no mem_ready, bus_err=1 that cycle, no hit is generated, and next state is IDLE. mem_ready in the same cycle takes precedence (normal completion, no bus_err).
- starve_cnt saturates at STARVE_LIMIT; it is unchanged by data grants when no fetch is pending.
- rst asserted mid-transaction: the next edge returns to IDLE; the pending hit is never issued and mem strobes drop.
- The block has no combinational path from requester inputs to mem_* outputs.

Test Plan:
- Fetch only: imem_ren=1, addr 0x100; mem_ready 2 cycles after strobe with mem_load 0x00000013 -> mem_ren=1, mem_addr=0x100, mem_width=3'b010; ihit pulse with imem_load=0x13 in the mem_ready cycle; IDLE next.
- Simultaneous requests: imem_ren, and dmem_ren at 0x2000 width 3'b010, mem_ready immediate -> DBUSY first with dhit, then IDLE, then IBUSY with ihit.
- Starvation with STARVE_LIMIT=2: dmem_wen and imem_ren held continuously, mem_ready immediate -> grant order D, D, I, D, D, I.
- Store: dmem_wen=1, addr 0x3004, store 0xDEADBEEF, width 3'b001 -> mem_wen=1, mem_store=0xDEADBEEF, mem_width=3'b001, mem_ren=0; dhit on mem_ready.
- Timeout with TIMEOUT_CYCLES=4: mem_ready never asserted -> bus_err pulses on the 4th busy cycle, no hit, IDLE next; mem_ready on the 4th cycle -> hit, no bus_err.
- Reset during DBUSY: rst=1 for one edge while waiting, then mem_ready=1 -> no dhit, state IDLE, mem_ren=0, starve_cnt=0.
